zle_xc4_dec: RTL and testbench

//  Zero run-length decoder; directly downstream of the ZLE encoder (zle_xc4_*).

---
 rtl/zle_xc4_dec.sv | 159 +++++++++++++++
 tb/tb_zle_xc4_dec.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zle_xc4_dec.sv
// ---------------------------------------------------------------------------
// zle_xc4_dec -- zero run-length decoder
//
// Sits directly after the ZLE encoder. It takes encoder tokens and rebuilds
// the original DW-bit sample stream. Each token is one of two kinds:
//   {1, cnt}   a run of cnt zero samples (cnt = 1 .. 2**CW-1)
//   {0, value} one literal sample
// A sticky error flag records malformed tokens. A malformed token is either
// a zero-length run, which is dropped, or a literal of value 0, which is
// still emitted.
//
// Ports
//   clock  in       rising-edge clock
//   reset  in       asynchronous, active-high; clears all state
//   i_d    in  TW   token, where bit TW-1 is the run flag
//   i_v    in       token valid
//   i_b    out      back-pressure to the encoder (1 = not accepting)
//   o_d    out DW   decoded sample (0 whenever o_v = 0)
//   o_v    out      sample valid
//   o_b    in       back-pressure from the consumer (1 = stall)
//   err    out      sticky malformed-token flag, cleared only by reset
// ---------------------------------------------------------------------------
module zle_xc4_dec #(
    parameter int  DW = 3,
    parameter int  CW = 4,
    localparam int TW = ((DW > CW) ? DW : CW) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [TW-1:0] i_d,
    input  logic          i_v,
    output logic          i_b,
    output logic [DW-1:0] o_d,
    output logic          o_v,
    input  logic          o_b,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LIT  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] LIT_ZERO = {DW{1'b0}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] lit_q,   lit_d;
    logic          err_q,   err_d;

    logic          accept_s;
    logic          tok_run_s;
    logic [CW-1:0] tok_cnt_s;
    logic [DW-1:0] tok_lit_s;

    assign accept_s  = i_v & ~i_b;
    assign tok_run_s = i_d[TW-1];
    assign tok_cnt_s = i_d[CW-1:0];
    assign tok_lit_s = i_d[DW-1:0];
    assign err       = err_q;

    // State register: FSM state, run counter, literal holding register, error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            lit_q   <= LIT_ZERO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lit_q   <= lit_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: token decode in idle, sample hand-off in LIT and RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lit_d   = lit_q;
        err_d   = err_q;
        case (state_q)
            S_LIT: begin
                if (!o_b) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LIT;
                end
            end
            S_RUN: begin
                // Exiting on cnt == 1 means the counter never decrements through zero.
                if (!o_b) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = CNT_ZERO;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                // Idle, and also the recovery path for the unused encoding.
                // i_b is low here, so a token presented now must be consumed.
                state_d = S_IDLE;
                if (accept_s) begin
                    if (tok_run_s) begin
                        if (tok_cnt_s == CNT_ZERO) begin
                            err_d = 1'b1;
                        end else begin
                            cnt_d   = tok_cnt_s;
                            state_d = S_RUN;
                        end
                    end else begin
                        lit_d   = tok_lit_s;
                        state_d = S_LIT;
                        if (tok_lit_s == LIT_ZERO) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Output decode from registered state. reset forces i_b high while it is asserted.
    always_comb begin
        o_v = 1'b0;
        o_d = LIT_ZERO;
        i_b = 1'b1;
        case (state_q)
            S_LIT: begin
                o_v = 1'b1;
                o_d = lit_q;
                i_b = 1'b1;
            end
            S_RUN: begin
                o_v = 1'b1;
                o_d = LIT_ZERO;
                i_b = 1'b1;
            end
            default: begin
                o_v = 1'b0;
                o_d = LIT_ZERO;
                i_b = reset;
            end
        endcase
    end

endmodule

// File: tb/tb_zle_xc4_dec.sv
// ---------------------------------------------------------------------------
// tb_zle_xc4_dec -- directed self-checking bench for zle_xc4_dec (DW=3, CW=4)
//
// Inputs are driven on the falling edge and outputs are sampled there too,
// well away from the rising edge where the design updates.
// ---------------------------------------------------------------------------
module tb_zle_xc4_dec;

    logic       clock;
    logic       reset;
    logic [4:0] i_d;
    logic       i_v;
    logic       i_b;
    logic [2:0] o_d;
    logic       o_v;
    logic       o_b;
    logic       err;

    int n_pass;
    int n_total;

    zle_xc4_dec #(.DW(3), .CW(4)) dut (
        .clock (clock),
        .reset (reset),
        .i_d   (i_d),
        .i_v   (i_v),
        .i_b   (i_b),
        .o_d   (o_d),
        .o_v   (o_v),
        .o_b   (o_b),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1;
        i_v   = 1'b0;
        i_d   = 5'd0;
        o_b   = 1'b0;
        repeat (2) @(negedge clock);
        n_total++; if (o_v !== 1'b0) $display("FAIL reset_o_v got=%b want=0", o_v); else n_pass++;
        n_total++; if (o_d !== 3'd0) $display("FAIL reset_o_d got=%0d want=0", o_d); else n_pass++;
        n_total++; if (i_b !== 1'b1) $display("FAIL reset_i_b got=%b want=1", i_b); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (i_b !== 1'b0) $display("FAIL release_i_b got=%b want=0", i_b); else n_pass++;
    endtask

    task automatic test_literal();
        i_d = {1'b0, 4'd5};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1) $display("FAIL lit5_o_v got=%b want=1", o_v); else n_pass++;
        n_total++; if (o_d !== 3'd5) $display("FAIL lit5_o_d got=%0d want=5", o_d); else n_pass++;
        n_total++; if (i_b !== 1'b1) $display("FAIL lit5_i_b got=%b want=1", i_b); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL lit5_err got=%b want=0", err); else n_pass++;
        @(negedge clock);
        n_total++; if (o_v !== 1'b0) $display("FAIL lit5_done_o_v got=%b want=0", o_v); else n_pass++;
        n_total++; if (o_d !== 3'd0) $display("FAIL lit5_done_o_d got=%0d want=0", o_d); else n_pass++;
        n_total++; if (i_b !== 1'b0) $display("FAIL lit5_done_i_b got=%b want=0", i_b); else n_pass++;
    endtask

    task automatic test_long_run();
        i_d = {1'b1, 4'd15};
        i_v = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            i_v = 1'b0;
            n_total++;
            if (o_v !== 1'b1 || o_d !== 3'd0 || i_b !== 1'b1)
                $display("FAIL run15_sample%0d got o_v=%b o_d=%0d i_b=%b want 1/0/1", k, o_v, o_d, i_b);
            else n_pass++;
        end
        @(negedge clock);
        n_total++; if (o_v !== 1'b0) $display("FAIL run15_end_o_v got=%b want=0", o_v); else n_pass++;
        n_total++; if (i_b !== 1'b0) $display("FAIL run15_end_i_b got=%b want=0", i_b); else n_pass++;
        i_d = {1'b0, 4'd7};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1 || o_d !== 3'd7) $display("FAIL lit7 got o_v=%b o_d=%0d want 1/7", o_v, o_d); else n_pass++;
        @(negedge clock);
        n_total++; if (o_v !== 1'b0) $display("FAIL lit7_done_o_v got=%b want=0", o_v); else n_pass++;
    endtask

    task automatic test_stall_run();
        int xfers;
        xfers = 0;
        i_d = {1'b1, 4'd3};
        i_v = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            i_v = 1'b0;
            o_b = (c >= 2 && c <= 5);
            if (o_b) begin
                n_total++;
                if (o_v !== 1'b1 || o_d !== 3'd0)
                    $display("FAIL stall_frozen_c%0d got o_v=%b o_d=%0d want 1/0", c, o_v, o_d);
                else n_pass++;
            end
            if (o_v === 1'b1 && o_b === 1'b0) xfers++;
        end
        o_b = 1'b0;
        n_total++; if (xfers !== 3) $display("FAIL stall_xfer_count got=%0d want=3", xfers); else n_pass++;
        n_total++; if (o_v !== 1'b0 || i_b !== 1'b0) $display("FAIL stall_end got o_v=%b i_b=%b want 0/0", o_v, i_b); else n_pass++;
    endtask

    task automatic test_errors();
        i_d = {1'b1, 4'd0};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b0) $display("FAIL run0_o_v got=%b want=0", o_v); else n_pass++;
        n_total++; if (i_b !== 1'b0) $display("FAIL run0_i_b got=%b want=0", i_b); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL run0_err got=%b want=1", err); else n_pass++;
        repeat (3) @(negedge clock);
        n_total++; if (err !== 1'b1 || o_v !== 1'b0) $display("FAIL run0_sticky got err=%b o_v=%b want 1/0", err, o_v); else n_pass++;
        i_d = {1'b0, 4'd2};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1 || o_d !== 3'd2) $display("FAIL lit2 got o_v=%b o_d=%0d want 1/2", o_v, o_d); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL lit2_err got=%b want=1", err); else n_pass++;
        @(negedge clock);
        // Clear err so that the zero literal below must raise it on its own.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL err_cleared got=%b want=0", err); else n_pass++;
        i_d = {1'b0, 4'd0};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1 || o_d !== 3'd0) $display("FAIL lit0 got o_v=%b o_d=%0d want 1/0", o_v, o_d); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL lit0_err got=%b want=1", err); else n_pass++;
        @(negedge clock);
        n_total++; if (o_v !== 1'b0) $display("FAIL lit0_done_o_v got=%b want=0", o_v); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        i_d = {1'b1, 4'd10};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1) $display("FAIL run10_first got o_v=%b want=1", o_v); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_total++; if (o_v !== 1'b0) $display("FAIL midrst_o_v got=%b want=0", o_v); else n_pass++;
        n_total++; if (o_d !== 3'd0) $display("FAIL midrst_o_d got=%0d want=0", o_d); else n_pass++;
        n_total++; if (i_b !== 1'b1) $display("FAIL midrst_i_b got=%b want=1", i_b); else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_total++; if (err !== 1'b0) $display("FAIL midrst_err got=%b want=0", err); else n_pass++;
        n_total++; if (i_b !== 1'b0 || o_v !== 1'b0) $display("FAIL midrst_idle got i_b=%b o_v=%b want 0/0", i_b, o_v); else n_pass++;
        i_d = {1'b0, 4'd3};
        i_v = 1'b1;
        @(negedge clock);
        i_v = 1'b0;
        n_total++; if (o_v !== 1'b1 || o_d !== 3'd3) $display("FAIL midrst_lit3 got o_v=%b o_d=%0d want 1/3", o_v, o_d); else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [4:0] toks [5];
        logic [2:0] exp_q [$];
        int t;
        int idx;
        int cyc;
        // Source stream 4,0,0,0,6 followed by 23 zeros, hand-encoded into tokens.
        toks[0] = {1'b0, 4'd4};
        toks[1] = {1'b1, 4'd3};
        toks[2] = {1'b0, 4'd6};
        toks[3] = {1'b1, 4'd15};
        toks[4] = {1'b1, 4'd8};
        exp_q = {3'd4, 3'd0, 3'd0, 3'd0, 3'd6};
        for (int k = 0; k < 23; k++) exp_q.push_back(3'd0);
        t   = 0;
        idx = 0;
        cyc = 0;
        while ((idx < 28 || t < 5) && cyc < 400) begin
            @(negedge clock);
            cyc++;
            o_b = ($urandom_range(0, 3) == 0);
            if (o_v === 1'b1 && o_b === 1'b0) begin
                n_total++;
                if (idx >= 28) $display("FAIL b2b_extra_sample got=%0d want=none", o_d);
                else if (o_d !== exp_q[idx]) $display("FAIL b2b_sample%0d got=%0d want=%0d", idx, o_d, exp_q[idx]);
                else n_pass++;
                idx++;
            end
            if (t < 5) begin
                i_v = 1'b1;
                i_d = toks[t];
                if (i_b === 1'b0) t++;
            end else begin
                i_v = 1'b0;
            end
        end
        n_total++; if (idx !== 28) $display("FAIL b2b_sample_count got=%0d want=28", idx); else n_pass++;
        i_v = 1'b0;
        o_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_total++; if (o_v !== 1'b0) $display("FAIL b2b_trailing%0d got o_v=%b want=0", k, o_v); else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_literal();
        test_long_run();
        test_stall_run();
        test_errors();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
